// File: rtl/logic_wb_arbiter_if.sv
// Bus bundle for logic_wb_arbiter: two Wishbone masters sharing one register slave.
// The slave modport is the arbiter's view; the master modport is the requesters/slave-model view.
interface logic_wb_arbiter_if;
    logic       m0_cyc_i;
    logic       m0_stb_i;
    logic       m0_we_i;
    logic [1:0] m0_adr_i;
    logic [7:0] m0_dat_i;
    logic [7:0] m0_dat_o;
    logic       m0_ack_o;
    logic       m0_err_o;

    logic       m1_cyc_i;
    logic       m1_stb_i;
    logic       m1_we_i;
    logic [1:0] m1_adr_i;
    logic [7:0] m1_dat_i;
    logic [7:0] m1_dat_o;
    logic       m1_ack_o;
    logic       m1_err_o;

    logic       s_cyc_o;
    logic       s_stb_o;
    logic       s_we_o;
    logic [1:0] s_adr_o;
    logic [7:0] s_dat_o;
    logic [7:0] s_dat_i;
    logic       s_ack_i;

    modport slave (
        input  m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i,
        input  m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i,
        input  s_dat_i, s_ack_i,
        output m0_dat_o, m0_ack_o, m0_err_o,
        output m1_dat_o, m1_ack_o, m1_err_o,
        output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o
    );

    modport master (
        output m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i,
        output m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i,
        output s_dat_i, s_ack_i,
        input  m0_dat_o, m0_ack_o, m0_err_o,
        input  m1_dat_o, m1_ack_o, m1_err_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o
    );
endinterface

// File: rtl/logic_wb_arbiter.sv
// Round-robin two-master Wishbone arbiter for a single 2-bit-address, 8-bit register slave.
// Define LOGIC_ARB_TIMEOUT_EN to add the strobe-wait timeout counter and ABORT state.
module logic_wb_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n_i,
    logic_wb_arbiter_if.slave bus
);

`ifdef LOGIC_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {StIdle, StOwn, StAbort} state_e;
`else
    typedef enum logic [0:0] {StIdle, StOwn} state_e;
`endif

    state_e     r_state, w_state_d;
    logic       r_owner, w_owner_d;
    logic       r_last, w_last_d;
    logic       w_own_cyc, w_own_stb, w_own_we;
    logic [1:0] w_own_adr;
    logic [7:0] w_own_dat;
    logic       w_fwd, w_ack, w_timeout;

    always_comb begin
        w_own_cyc = r_owner ? bus.m1_cyc_i : bus.m0_cyc_i;
        w_own_stb = r_owner ? bus.m1_stb_i : bus.m0_stb_i;
        w_own_we  = r_owner ? bus.m1_we_i  : bus.m0_we_i;
        w_own_adr = r_owner ? bus.m1_adr_i : bus.m0_adr_i;
        w_own_dat = r_owner ? bus.m1_dat_i : bus.m0_dat_i;
    end

    assign w_fwd = (r_state == StOwn);
    // An ack only counts while a strobe is actually being forwarded.
    assign w_ack = w_fwd & w_own_stb & bus.s_ack_i;

`ifdef LOGIC_ARB_TIMEOUT_EN
    logic [7:0] r_cnt, w_cnt_d;
    logic       w_wait;

    assign w_wait    = w_fwd & w_own_cyc & w_own_stb & ~bus.s_ack_i;
    assign w_timeout = w_wait & (r_cnt == 8'(TIMEOUT - 1));
    assign w_cnt_d   = (w_wait && !w_timeout) ? r_cnt + 8'd1 : 8'd0;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_cnt <= 8'd0;
        end else begin
            r_cnt <= w_cnt_d;
        end
    end
`else
    logic [7:0] w_unused_timeout;

    assign w_unused_timeout = 8'(TIMEOUT);
    assign w_timeout        = 1'b0;
`endif

    always_comb begin
        w_state_d = r_state;
        w_owner_d = r_owner;
        w_last_d  = r_last;
        case (r_state)
            StIdle: begin
                if (bus.m0_cyc_i || bus.m1_cyc_i) begin
                    w_state_d = StOwn;
                    w_owner_d = (bus.m0_cyc_i && bus.m1_cyc_i) ? ~r_last : bus.m1_cyc_i;
                end
            end
            StOwn: begin
                if (!w_own_cyc) begin
                    w_state_d = StIdle;
                    w_last_d  = r_owner;
`ifdef LOGIC_ARB_TIMEOUT_EN
                end else if (w_timeout) begin
                    w_state_d = StAbort;
`endif
                end
            end
`ifdef LOGIC_ARB_TIMEOUT_EN
            StAbort: begin
                if (!w_own_cyc) begin
                    w_state_d = StIdle;
                    w_last_d  = r_owner;
                end
            end
`endif
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_state <= StIdle;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_d;
            r_owner <= w_owner_d;
            r_last  <= w_last_d;
        end
    end

    always_comb begin
        bus.s_cyc_o  = 1'b0;
        bus.s_stb_o  = 1'b0;
        bus.s_we_o   = 1'b0;
        bus.s_adr_o  = 2'd0;
        bus.s_dat_o  = 8'd0;
        bus.m0_dat_o = 8'd0;
        bus.m1_dat_o = 8'd0;
        bus.m0_ack_o = w_ack & ~r_owner;
        bus.m1_ack_o = w_ack & r_owner;
        bus.m0_err_o = w_timeout & ~r_owner;
        bus.m1_err_o = w_timeout & r_owner;
        if (w_fwd) begin
            bus.s_cyc_o = w_own_cyc;
            bus.s_stb_o = w_own_stb;
            bus.s_we_o  = w_own_we;
            bus.s_adr_o = w_own_adr;
            bus.s_dat_o = w_own_dat;
            if (r_owner) begin
                bus.m1_dat_o = bus.s_dat_i;
            end else begin
                bus.m0_dat_o = bus.s_dat_i;
            end
        end
    end

endmodule

// File: doc/logic_wb_arbiter.md
LOGIC_WB_ARBITER -- requirements
Module: logic_wb_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15: cycles a granted strobe may wait for s_ack_i before abort (used only under LOGIC_ARB_TIMEOUT_EN), legal range 1..255.
REQ-002 wb_clk_i  in  1  single clock; all state changes on its rising edge.
REQ-003 wb_rst_n_i  in  1  reset; asynchronous, active-low.
REQ-004 m<n>_cyc_i  in  1  master n (n=0,1) bus-cycle request.
REQ-005 m<n>_stb_i  in  1  master n strobe.
REQ-006 m<n>_we_i  in  1  master n write enable.
REQ-007 m<n>_adr_i  in  2  master n register address.
REQ-008 m<n>_dat_i  in  8  master n write data.
REQ-009 m<n>_dat_o  out  8  read data to master n.
REQ-010 m<n>_ack_o  out  1  acknowledge to master n.
REQ-011 m<n>_err_o  out  1  abort indication to master n.
REQ-012 s_cyc_o, s_stb_o, s_we_o  out  1 each  slave cycle, strobe and write enable.
REQ-013 s_adr_o  out  2 / s_dat_o  out  8  slave address and write data.
REQ-014 s_dat_i  in  8 / s_ack_i  in  1  slave read data and acknowledge.

Function
REQ-015 The arbiter SHALL share one 2-bit-address, 8-bit Wishbone register slave between masters 0 and 1 using FSM states IDLE, OWN and ABORT, plus an owner flag and a last-granted flag.
REQ-016 In IDLE, if exactly one mN_cyc_i is high, the arbiter SHALL enter OWN with that master as owner on the next edge.
REQ-017 In IDLE, if both mN_cyc_i are high, the arbiter SHALL grant the master other than last-granted (round-robin).
REQ-018 Grant latency SHALL be exactly one cycle from cyc seen in IDLE to s_cyc_o high; nothing is forwarded in IDLE.
REQ-019 In OWN, s_cyc_o/s_stb_o/s_we_o/s_adr_o/s_dat_o SHALL be combinational copies of the owner's inputs.
REQ-020 In OWN, owner mN_ack_o SHALL equal s_ack_i and owner mN_dat_o SHALL equal s_dat_i, combinationally (zero added latency).
REQ-021 The non-owner's ack_o, err_o and dat_o SHALL be 0 at all times; in IDLE and ABORT all s_* outputs and all m*_ack_o/m*_dat_o SHALL be 0.
REQ-022 Ownership SHALL persist over any number of strobes while owner cyc stays high; the other master's requests are ignored.
REQ-023 When the owner drops cyc in OWN, the FSM SHALL return to IDLE on that edge and set last-granted to the owner; a new grant SHALL need at least one IDLE cycle.
REQ-024 s_ack_i while no strobe is forwarded SHALL be ignored.

Reset
REQ-025 wb_rst_n_i low SHALL immediately force IDLE, owner 0, last-granted 1 (master 0 wins the first tie), timeout counter 0, and all outputs 0.
REQ-026 Reset mid-transfer SHALL abandon the cycle with no ack or err to either master; after release, arbitration SHALL restart from IDLE.

Configuration
REQ-027 With LOGIC_ARB_TIMEOUT_EN defined, an 8-bit counter SHALL count OWN cycles with owner stb high and s_ack_i low, clearing on ack or stb low.
REQ-028 With LOGIC_ARB_TIMEOUT_EN defined, the counter reaching TIMEOUT SHALL pulse owner mN_err_o for one cycle, enter ABORT (s_* outputs 0), and return to IDLE once owner cyc is low.
REQ-029 Without LOGIC_ARB_TIMEOUT_EN, no counter or ABORT state SHALL exist, both mN_err_o SHALL be tied 0, and OWN SHALL wait indefinitely for s_ack_i.

Verification
REQ-030 Reset release; m0 writes 0x5A to adr 0 with slave acking at once -> s_cyc_o high one cycle after m0_cyc_i, m0_ack_o in the same cycle as s_ack_i, s_dat_o=0x5A.
REQ-031 m0 and m1 raise cyc on the same cycle after reset -> m0 granted first; m1 granted after m0 drops cyc plus one IDLE cycle; next simultaneous request -> m0 granted after m1.
REQ-032 m1 owns the bus for a 3-strobe burst while m0 holds cyc -> m0_ack_o stays 0 throughout; m0 granted only after m1 drops cyc.
REQ-033 m1 reads adr 3 with s_dat_i=0xF0 -> m1_dat_o=0xF0 while m1_ack_o is high; m0_dat_o stays 0x00.
REQ-034 With LOGIC_ARB_TIMEOUT_EN and TIMEOUT=4, slave never acks m0 -> m0_err_o pulses once on the 4th waiting cycle, s_cyc_o falls, FSM returns to IDLE after m0 drops cyc; without the macro, no err and the cycle hangs.
REQ-035 wb_rst_n_i pulsed low during an m1 transfer -> all outputs 0 immediately, no ack/err, next tie granted to m0.
